// File: rtl/bluetooth_status_tx.sv
// Status reporter: serialises {HEADER, current, volume} as 8N1 UART whenever the inputs change or a report is forced.
// Optional BT_TX_CHECKSUM_EN appends an XOR checksum byte (5-byte frame instead of 4).
//
// state | meaning
// IDLE  | TXD high; snapshots inputs and starts a frame when pending
// START | start bit (TXD low) for BAUD_DIV cycles
// DATA  | 8 data bits, LSB first, BAUD_DIV cycles each
// STOP  | stop bit (TXD high); next byte or back to IDLE
module bluetooth_status_tx #(
  parameter int         BAUD_DIV = 5208,
  parameter logic [7:0] HEADER   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  current,
  input  logic [15:0] volume,
  input  logic        send_req,
  output logic        TXD,
  output logic        busy,
  output logic        frame_done
);

`ifdef BT_TX_CHECKSUM_EN
  localparam int NBYTES = 5;
`else
  localparam int NBYTES = 4;
`endif
  localparam int FW = NBYTES * 8;
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [2:0]    LAST_BYTE = 3'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] baud_q, baud_n;
  logic [2:0]    bit_q, bit_n;
  logic [2:0]    byte_q, byte_n;
  logic [FW-1:0] shift_q, shift_n;
  logic [2:0]    last_cur_q, last_cur_n;
  logic [15:0]   last_vol_q, last_vol_n;
  logic          pending_q, pending_n;
  logic          txd_q, txd_n;
  logic          baud_tc, snap, change;
  logic [FW-1:0] frame_snap;

  // Byte 0 sits in the low bits so the whole buffer shifts right one bit per data bit.
`ifdef BT_TX_CHECKSUM_EN
  assign frame_snap = {HEADER ^ {5'b0, current} ^ volume[15:8] ^ volume[7:0],
                       volume[7:0], volume[15:8], {5'b0, current}, HEADER};
`else
  assign frame_snap = {volume[7:0], volume[15:8], {5'b0, current}, HEADER};
`endif

  assign baud_tc = (baud_q == BAUD_LAST);
  assign change  = (current != last_cur_q) || (volume != last_vol_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      shift_q    <= '0;
      last_cur_q <= '0;
      last_vol_q <= '0;
      pending_q  <= 1'b1;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_n;
      baud_q     <= baud_n;
      bit_q      <= bit_n;
      byte_q     <= byte_n;
      shift_q    <= shift_n;
      last_cur_q <= last_cur_n;
      last_vol_q <= last_vol_n;
      pending_q  <= pending_n;
      txd_q      <= txd_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    baud_n     = baud_q;
    bit_n      = bit_q;
    byte_n     = byte_q;
    shift_n    = shift_q;
    last_cur_n = last_cur_q;
    last_vol_n = last_vol_q;
    frame_done = 1'b0;
    snap       = 1'b0;
    txd_n      = 1'b1;

    if (state_q != S_IDLE) baud_n = baud_tc ? '0 : baud_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          snap       = 1'b1;
          shift_n    = frame_snap;
          last_cur_n = current;
          last_vol_n = volume;
          byte_n     = '0;
          baud_n     = '0;
          state_n    = S_START;
        end
      end
      S_START: begin
        if (baud_tc) begin
          bit_n   = '0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tc) begin
          shift_n = shift_q >> 1;
          if (bit_q == 3'd7) state_n = S_STOP;
          else               bit_n   = bit_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_tc) begin
          if (byte_q == LAST_BYTE) begin
            frame_done = 1'b1;
            state_n    = S_IDLE;
          end else begin
            byte_n  = byte_q + 1'b1;
            state_n = S_START;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A difference seen in the snapshot cycle is being captured right now, so it is not a new event.
    if (send_req || (change && !snap)) pending_n = 1'b1;
    else if (snap)                     pending_n = 1'b0;
    else                               pending_n = pending_q;

    case (state_n)
      S_START: txd_n = 1'b0;
      S_DATA:  txd_n = shift_n[0];
      default: txd_n = 1'b1;
    endcase
  end

  assign TXD  = txd_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_bluetooth_status_tx.sv
// Bench for bluetooth_status_tx: UART receiver + frame scoreboard, frame timing checker, directed and random stimulus.
module tb_bluetooth_status_tx;

  localparam int BD = 4;
`ifdef BT_TX_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int FL = NB * 10 * BD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  current = 3'd0;
  logic [15:0] volume = 16'd0;
  logic        send_req = 1'b0;
  logic        TXD, busy, frame_done;

  bluetooth_status_tx #(.BAUD_DIV(BD), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst), .current(current), .volume(volume), .send_req(send_req),
    .TXD(TXD), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  logic [39:0] exp_q[$];

  task automatic check(input bit ok, input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference frame straight from the byte list: header, track, volume hi, volume lo, optional XOR.
  function automatic logic [39:0] mk_frame(input logic [2:0] c, input logic [15:0] v);
    logic [7:0] b [5];
    logic [39:0] f;
    b[0] = 8'hA5;
    b[1] = {5'b0, c};
    b[2] = v[15:8];
    b[3] = v[7:0];
    b[4] = b[0] ^ b[1] ^ b[2] ^ b[3];
    f = '0;
    for (int i = 0; i < NB; i++) f = f | (40'(b[i]) << (8 * i));
    return f;
  endfunction

  task automatic push_frame(input logic [2:0] c, input logic [15:0] v);
    exp_q.push_back(mk_frame(c, v));
  endtask

  // Mid-bit sampling UART receiver feeding the scoreboard.
  initial begin
    int ph, cnt, nbit, nby;
    logic [7:0]  rx_byte;
    logic [39:0] rx_frame, e;
    ph = 0; cnt = 0; nbit = 0; nby = 0; rx_byte = '0; rx_frame = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ph = 0; nby = 0; rx_frame = '0;
      end else if (ph == 0) begin
        if (TXD == 1'b0) begin ph = 1; cnt = BD / 2 - 1; end
      end else begin
        cnt--;
        if (cnt == 0) begin
          cnt = BD;
          case (ph)
            1: begin
              check(TXD == 1'b0, "start_bit", 40'(TXD), 40'(0));
              ph = 2; nbit = 0;
            end
            2: begin
              rx_byte[nbit] = TXD;
              nbit++;
              if (nbit == 8) ph = 3;
            end
            default: begin
              check(TXD == 1'b1, "stop_bit", 40'(TXD), 40'(1));
              rx_frame = rx_frame | (40'(rx_byte) << (8 * nby));
              nby++;
              ph = 0;
              if (nby == NB) begin
                if (exp_q.size() == 0) begin
                  check(1'b0, "unexpected_frame", rx_frame, 40'(0));
                end else begin
                  e = exp_q.pop_front();
                  check(rx_frame == e, "frame", rx_frame, e);
                end
                nby = 0; rx_frame = '0;
              end
            end
          endcase
        end
      end
    end
  end

  // Frame length, start-bit alignment with busy, and minimum idle gap.
  initial begin
    bit prev_busy, have_done;
    int fstart, last_done;
    prev_busy = 1'b0; have_done = 1'b0; fstart = 0; last_done = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0; have_done = 1'b0;
      end else begin
        if (busy && !prev_busy) begin
          fstart = cyc;
          check(TXD == 1'b0, "busy_start_txd", 40'(TXD), 40'(0));
          if (have_done) check(cyc - last_done >= 2, "idle_gap", 40'(cyc - last_done), 40'(2));
        end
        if (frame_done) begin
          check(cyc - fstart == FL - 1, "frame_len", 40'(cyc - fstart + 1), 40'(FL));
          last_done = cyc;
          have_done = 1'b1;
        end
        prev_busy = busy;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * FL && !seen; i++) begin
      @(negedge clk);
      seen = busy;
    end
    check(seen, "busy_timeout", 40'(busy), 40'(1));
  endtask

  task automatic wait_idle();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 6 * FL && quiet < 3; i++) begin
      @(negedge clk);
      quiet = busy ? 0 : quiet + 1;
    end
    check(quiet >= 3, "idle_timeout", 40'(busy), 40'(0));
  endtask

  task automatic pulse_send();
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    bit owed, seen, stayed;
    logic [2:0]  sc;
    logic [15:0] sv;

    // Reset release with zero inputs: one frame follows reset.
    rst = 1'b1; current = 3'd0; volume = 16'h0000;
    repeat (3) tick();
    rst = 1'b0;
    push_frame(3'd0, 16'h0000);
    @(negedge clk);
    check(TXD == 1'b1 && busy == 1'b0, "release_c1", {38'd0, TXD, busy}, {38'd0, 2'b10});
    @(negedge clk);
    check(TXD == 1'b0 && busy == 1'b1, "release_c2", {38'd0, TXD, busy}, {38'd0, 2'b01});
    wait_idle();

    // Idle changes.
    tick(); current = 3'd2; volume = 16'h8080;
    push_frame(3'd2, 16'h8080);
    wait_idle();
    tick(); current = 3'd3;
    push_frame(3'd3, 16'h8080);

    // Volume change during B1: current frame unchanged, one follow-up after one idle cycle.
    wait_busy();
    repeat (15 * BD) @(negedge clk);
    tick(); volume = 16'h9090;
    push_frame(3'd3, 16'h9090);
    seen = 1'b0;
    for (int i = 0; i < 2 * FL && !seen; i++) begin
      @(negedge clk);
      seen = frame_done;
    end
    check(seen, "done_timeout", 40'(seen), 40'(1));
    @(negedge clk);
    check(busy == 1'b0 && TXD == 1'b1, "gap_idle", {38'd0, TXD, busy}, {38'd0, 2'b10});
    @(negedge clk);
    check(busy == 1'b1 && TXD == 1'b0, "gap_restart", {38'd0, TXD, busy}, {38'd0, 2'b01});
    wait_idle();

    // Three send_req pulses during one frame coalesce into one follow-up.
    tick(); pulse_send();
    push_frame(3'd3, 16'h9090);
    wait_busy();
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(5, 30)) tick();
      pulse_send();
    end
    push_frame(3'd3, 16'h9090);
    wait_idle();
    stayed = 1'b1;
    for (int i = 0; i < 2 * FL; i++) begin
      @(negedge clk);
      if (busy || !TXD) stayed = 1'b0;
    end
    check(stayed && exp_q.size() == 0, "quiet_after_coalesce", 40'(exp_q.size()), 40'(0));

    // Reset during data bit 5 of B2.
    tick(); current = 3'd1; volume = 16'h3070;
    push_frame(3'd1, 16'h3070);
    wait_busy();
    repeat (26 * BD + 1) @(negedge clk);
    tick(); rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check(TXD == 1'b1 && busy == 1'b0, "rst_midframe", {38'd0, TXD, busy}, {38'd0, 2'b10});
    current = 3'($urandom); volume = 16'($urandom);
    tick(); tick();
    rst = 1'b0;
    push_frame(current, volume);
    wait_idle();

    // Random phase.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        tick();
        sc = ($urandom_range(0, 1) == 0) ? current : 3'($urandom);
        sv = ($urandom_range(0, 1) == 0) ? volume : 16'($urandom);
        owed = (sc != current) || (sv != volume);
        current = sc; volume = sv;
        if ($urandom_range(0, 2) == 0) begin send_req = 1'b1; owed = 1'b1; end
        if (owed) push_frame(sc, sv);
        tick(); send_req = 1'b0;
        wait_idle();
      end else begin
        tick();
        sc = 3'($urandom); sv = 16'($urandom);
        current = sc; volume = sv;
        push_frame(sc, sv);
        pulse_send();
        wait_busy();
        owed = 1'b0;
        for (int k = 0; k < $urandom_range(1, 4); k++) begin
          repeat ($urandom_range(1, 20)) tick();
          if ($urandom_range(0, 2) == 0) begin
            pulse_send();
            owed = 1'b1;
          end else begin
            if ($urandom_range(0, 1) == 0) current = 3'($urandom);
            if ($urandom_range(0, 1) == 0) volume = 16'($urandom);
            if (current != sc || volume != sv) owed = 1'b1;
            tick();
          end
        end
        if (owed) push_frame(current, volume);
        wait_idle();
      end
    end

    repeat (4 * BD) @(negedge clk);
    check(exp_q.size() == 0, "scoreboard_drained", 40'(exp_q.size()), 40'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
